cpu_self_check: RTL and testbench
=================================

// Module: cpu_self_check
// PURPOSE
//  Synthesisable self-check sequencer wrapped around a CPU core. Holds the core in reset,
//  lets it run for a programmable cycle count or until halt, then reads back NUM_CHECKS
//  register-file / data-memory locations over a debug read port and compares each against
//  an expected value. Replaces hand-written per-program testbench checks; usable on FPGA.
// PARAMETERS
//  NUM_CHECKS    8   entries in external check table (>=1)
//  RESET_CYCLES  2   cycles cpu_rst held high after start (>=1)
//  CNT_W         16  width of run-length counter
//  DATA_W        32  register/memory word width
// PORTS
//  clk            in   1               clock, all state on rising edge
//  rst            in   1               asynchronous, active-low reset
//  start          in   1               1-cycle pulse, begins a run (honoured in IDLE/DONE only)
//  run_len        in   CNT_W           max RUN cycles; sampled at start
//  wait_halt      in   1               1: hitting run_len without halt is a timeout; sampled at start
//  cpu_rst        out  1               active-high reset to CPU core
//  cpu_en         out  1               CPU clock-enable; 1 only in RUN
//  cpu_halt       in   1               CPU retired halt (ebreak); ends RUN early
//  chk_idx        out  $clog2(NUM_CHECKS) (min 1)  check-table index
//  chk_is_mem     in   1               table: 0 = register, 1 = data-memory word
//  chk_addr       in   DATA_W          table: register number or byte address
//  chk_expect     in   DATA_W          table: expected value
//  chk_mask       in   DATA_W          table: compare mask (1 = compared bit)
//  dbg_req        out  1               debug read request
//  dbg_is_mem     out  1               copy of chk_is_mem, stable while dbg_req
//  dbg_addr       out  DATA_W          copy of chk_addr, stable while dbg_req
//  dbg_ack        in   1               read data valid; may be same cycle as dbg_req
//  dbg_rdata      in   DATA_W          read data, valid with dbg_ack
//  done           out  1               run + all checks complete
//  pass           out  1               done & fail_count==0 & !timeout
//  timeout        out  1               run_len reached with wait_halt=1 and no halt
//  fail_count     out  $clog2(NUM_CHECKS+1)  mismatching entries
//  first_fail     out  $clog2(NUM_CHECKS) (min 1)  index of first mismatch (0 if none)
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; cpu_rst=1, cpu_en=0, dbg_req=0, done=0, pass=0,
//   timeout=0, fail_count=0, first_fail=0, chk_idx=0, counters 0. Mid-run reset aborts all.
//  FSM IDLE -> RESET -> RUN -> ISSUE <-> (loop) -> DONE.
//  IDLE: cpu_rst=1. start -> RESET; clear done/pass/timeout/fail_count/first_fail/chk_idx.
//  RESET: cpu_rst=1 for exactly RESET_CYCLES cycles, then RUN.
//  RUN: cpu_rst=0, cpu_en=1; counter increments each RUN cycle.
//   cpu_halt=1 -> ISSUE next cycle (halt wins over simultaneous count hit).
//   count==run_len (checked before increment) -> ISSUE; timeout<=wait_halt.
//   run_len=0: zero RUN cycles, straight to ISSUE (timeout set if wait_halt).
//  ISSUE: cpu_rst=0, cpu_en=0 (core frozen, state preserved). dbg_req=1 with
//   dbg_is_mem/dbg_addr from table[chk_idx], held stable until the dbg_ack cycle.
//   On dbg_ack: mismatch iff (dbg_rdata ^ chk_expect) & chk_mask != 0; mismatch
//   increments fail_count (saturating) and, if first, loads first_fail<=chk_idx.
//   chk_idx==NUM_CHECKS-1 -> DONE, else chk_idx++ and dbg_req drops for one cycle
//   before the next request (one request in flight, ack at most once per request).
//   dbg_ack outside ISSUE ignored.
//  DONE: done=1, pass registered; cpu_en=0, cpu_rst=0 (state inspectable). start ->
//   RESET (rerun, results cleared). start in RESET/RUN/ISSUE ignored.
//  Latency: start to first dbg_req = 1 + RESET_CYCLES + RUN cycles.
// TESTING
//  1. Program add/sub/sub/addi/sw/lw, run_len=6, wait_halt=0, table {x3=10,x5=5,x9=60,
//     mem[8]=5} -> done=1, pass=1, fail_count=0, cpu_rst high exactly 2 cycles.
//  2. Same program, expect x7=1 but lw makes x7=5 at entry 2 -> fail_count=1,
//     first_fail=2, pass=0; second bad entry 4 leaves first_fail=2, fail_count=2.
//  3. wait_halt=1, run_len=10, no halt -> timeout=1, pass=0 even with all entries matching;
//     cpu_halt at RUN cycle 3 -> exactly 3 cpu_en cycles, timeout=0.
//  4. dbg_ack delayed 0,1,5 cycles randomly -> dbg_addr stable during req, each entry
//     checked once; mask 0x0000_00FF ignores upper-byte mismatch.
//  5. rst low during ISSUE (entry 3) -> immediate IDLE, cpu_rst=1, outputs at reset values;
//     new start reruns cleanly. start during RUN ignored; run_len=0 -> no cpu_en cycle.

Source files
------------

// File: rtl/cpu_self_check.sv
// Self-check sequencer: holds a CPU core in reset, runs it for a bounded number of cycles,
// then reads back a table of register/memory locations over a debug port and scores them.
module cpu_self_check #(
    parameter int unsigned NUM_CHECKS   = 8,
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned DATA_W       = 32,
    localparam int unsigned IDX_W       = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
    localparam int unsigned FC_W        = $clog2(NUM_CHECKS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  run_len,
    input  logic              wait_halt,
    output logic              cpu_rst,
    output logic              cpu_en,
    input  logic              cpu_halt,
    output logic [IDX_W-1:0]  chk_idx,
    input  logic              chk_is_mem,
    input  logic [DATA_W-1:0] chk_addr,
    input  logic [DATA_W-1:0] chk_expect,
    input  logic [DATA_W-1:0] chk_mask,
    output logic              dbg_req,
    output logic              dbg_is_mem,
    output logic [DATA_W-1:0] dbg_addr,
    input  logic              dbg_ack,
    input  logic [DATA_W-1:0] dbg_rdata,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [FC_W-1:0]   fail_count,
    output logic [IDX_W-1:0]  first_fail
);

    localparam int unsigned RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_ISSUE,
        S_GAP,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [RC_W-1:0]   rst_cnt;
    logic [CNT_W-1:0]  run_cnt;
    logic [CNT_W-1:0]  run_cnt_inc;
    logic [CNT_W-1:0]  run_len_q;
    logic              wait_halt_q;
    logic              start_ok;
    logic              rst_last;
    logic              run_last;
    logic              chk_last;
    logic              ack_hit;
    logic              mismatch;
    logic              cpu_rst_nxt;
    logic              cpu_en_nxt;
    logic              dbg_req_nxt;
    logic              done_nxt;

    assign start_ok    = start && ((state == S_IDLE) || (state == S_DONE));
    assign rst_last    = (rst_cnt == RC_W'(RESET_CYCLES - 1));
    assign run_cnt_inc = run_cnt + CNT_W'(1);
    assign run_last    = (run_cnt_inc == run_len_q);
    assign chk_last    = (chk_idx == IDX_W'(NUM_CHECKS - 1));
    assign ack_hit     = (state == S_ISSUE) && dbg_ack;
    assign mismatch    = |((dbg_rdata ^ chk_expect) & chk_mask);

    // State register; control outputs are registered from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cpu_rst <= 1'b1;
            cpu_en  <= 1'b0;
            dbg_req <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cpu_rst <= cpu_rst_nxt;
            cpu_en  <= cpu_en_nxt;
            dbg_req <= dbg_req_nxt;
            done    <= done_nxt;
        end
    end

    // Next-state logic; halt takes priority over the run-length limit
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RESET;
            S_RESET: if (rst_last) state_nxt = (run_len_q == '0) ? S_ISSUE : S_RUN;
            S_RUN:   if (cpu_halt || run_last) state_nxt = S_ISSUE;
            S_ISSUE: if (dbg_ack) state_nxt = chk_last ? S_DONE : S_GAP;
            S_GAP:   state_nxt = S_ISSUE;
            S_DONE:  if (start) state_nxt = S_RESET;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode of the upcoming state
    always_comb begin
        cpu_rst_nxt = 1'b0;
        cpu_en_nxt  = 1'b0;
        dbg_req_nxt = 1'b0;
        done_nxt    = 1'b0;
        case (state_nxt)
            S_IDLE, S_RESET: cpu_rst_nxt = 1'b1;
            S_RUN:           cpu_en_nxt  = 1'b1;
            S_ISSUE:         dbg_req_nxt = 1'b1;
            S_DONE:          done_nxt    = 1'b1;
            default:         ;
        endcase
    end

    // Counters, run parameters, scoreboard and debug request payload
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_cnt     <= '0;
            run_cnt     <= '0;
            run_len_q   <= '0;
            wait_halt_q <= 1'b0;
            timeout     <= 1'b0;
            pass        <= 1'b0;
            fail_count  <= '0;
            first_fail  <= '0;
            chk_idx     <= '0;
            dbg_is_mem  <= 1'b0;
            dbg_addr    <= '0;
        end else begin
            if (start_ok) begin
                run_len_q   <= run_len;
                wait_halt_q <= wait_halt;
                timeout     <= 1'b0;
                pass        <= 1'b0;
                fail_count  <= '0;
                first_fail  <= '0;
                chk_idx     <= '0;
                rst_cnt     <= '0;
                run_cnt     <= '0;
            end
            if (state == S_RESET) begin
                rst_cnt <= rst_cnt + RC_W'(1);
                if (state_nxt == S_ISSUE) timeout <= wait_halt_q;
            end
            if (state == S_RUN) begin
                run_cnt <= run_cnt_inc;
                if ((state_nxt == S_ISSUE) && !cpu_halt) timeout <= wait_halt_q;
            end
            if (ack_hit) begin
                if (mismatch) begin
                    if (fail_count != '1) fail_count <= fail_count + FC_W'(1);
                    if (fail_count == '0) first_fail <= chk_idx;
                end
                if (chk_last) pass <= !timeout && !mismatch && (fail_count == '0);
                else          chk_idx <= chk_idx + IDX_W'(1);
            end
            // Capture the table entry once per request so it stays stable until ack
            if ((state_nxt == S_ISSUE) && (state != S_ISSUE)) begin
                dbg_is_mem <= chk_is_mem;
                dbg_addr   <= chk_addr;
            end
        end
    end

endmodule

// File: tb/tb_cpu_self_check.sv
// Bench for cpu_self_check: a behavioural CPU/debug responder plus a table-level
// reference model predicting run length, timeout and the mismatch scoreboard.
module tb_cpu_self_check;

    localparam int unsigned NUM_CHECKS   = 8;
    localparam int unsigned RESET_CYCLES = 2;
    localparam int unsigned CNT_W        = 16;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned IDX_W        = 3;
    localparam int unsigned FC_W         = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  run_len = '0;
    logic              wait_halt = 1'b0;
    logic              cpu_rst;
    logic              cpu_en;
    logic              cpu_halt = 1'b0;
    logic [IDX_W-1:0]  chk_idx;
    logic              chk_is_mem;
    logic [DATA_W-1:0] chk_addr;
    logic [DATA_W-1:0] chk_expect;
    logic [DATA_W-1:0] chk_mask;
    logic              dbg_req;
    logic              dbg_is_mem;
    logic [DATA_W-1:0] dbg_addr;
    logic              dbg_ack = 1'b0;
    logic [DATA_W-1:0] dbg_rdata = '0;
    logic              done;
    logic              pass;
    logic              timeout;
    logic [FC_W-1:0]   fail_count;
    logic [IDX_W-1:0]  first_fail;

    // Check table and architectural state the "program" left behind
    logic              tbl_is_mem [NUM_CHECKS];
    logic [DATA_W-1:0] tbl_addr   [NUM_CHECKS];
    logic [DATA_W-1:0] tbl_exp    [NUM_CHECKS];
    logic [DATA_W-1:0] tbl_mask   [NUM_CHECKS];
    logic [DATA_W-1:0] regs [32];
    logic [DATA_W-1:0] mem  [16];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc = 0, en_cnt = 0, rst_hi = 0, n_acks = 0, first_req = -1, start_cyc = 0;
    int halt_at = 0;
    bit active = 1'b0, stray = 1'b0, delay_mode = 1'b0, busy = 1'b0;
    int dly = 0;
    logic              req_mem;
    logic [DATA_W-1:0] req_addr;

    assign chk_is_mem = tbl_is_mem[chk_idx];
    assign chk_addr   = tbl_addr[chk_idx];
    assign chk_expect = tbl_exp[chk_idx];
    assign chk_mask   = tbl_mask[chk_idx];

    cpu_self_check #(
        .NUM_CHECKS(NUM_CHECKS), .RESET_CYCLES(RESET_CYCLES), .CNT_W(CNT_W), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .run_len(run_len), .wait_halt(wait_halt),
        .cpu_rst(cpu_rst), .cpu_en(cpu_en), .cpu_halt(cpu_halt), .chk_idx(chk_idx),
        .chk_is_mem(chk_is_mem), .chk_addr(chk_addr), .chk_expect(chk_expect),
        .chk_mask(chk_mask), .dbg_req(dbg_req), .dbg_is_mem(dbg_is_mem),
        .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .done(done),
        .pass(pass), .timeout(timeout), .fail_count(fail_count), .first_fail(first_fail)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] cpu_read(input logic is_mem, input logic [DATA_W-1:0] addr);
        return is_mem ? mem[addr[5:2]] : regs[addr[4:0]];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_entry(input int i, input logic is_mem, input logic [31:0] addr,
                             input logic [31:0] exp, input logic [31:0] mask);
        tbl_is_mem[i] = is_mem;
        tbl_addr[i]   = addr;
        tbl_exp[i]    = exp;
        tbl_mask[i]   = mask;
    endtask

    // Program result: add/sub/sub/addi/sw/lw leaves x3=10 x5=5 x7=5 x9=60 mem[8]=5
    task automatic load_program();
        for (int i = 0; i < 32; i++) regs[i] = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        regs[1] = 32'd7;  regs[2] = 32'd3;  regs[3] = 32'd10;
        regs[5] = 32'd5;  regs[7] = 32'd5;  regs[9] = 32'd60;
        mem[2]  = 32'd5;
        set_entry(0, 1'b0, 32'd3, 32'd10, '1);
        set_entry(1, 1'b0, 32'd5, 32'd5,  '1);
        set_entry(2, 1'b0, 32'd9, 32'd60, '1);
        set_entry(3, 1'b1, 32'd8, 32'd5,  '1);
        set_entry(4, 1'b0, 32'd7, 32'd5,  '1);
        set_entry(5, 1'b0, 32'd0, 32'd0,  '1);
        set_entry(6, 1'b0, 32'd1, 32'd7,  '1);
        set_entry(7, 1'b0, 32'd2, 32'd3,  '1);
    endtask

    // CPU model and debug responder, sampled 1 time unit after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            dbg_ack = 1'b0;
            if (active) begin
                if (cpu_rst) rst_hi++;
                if (cpu_en)  en_cnt++;
            end
            cpu_halt = active && cpu_en && (halt_at != 0) && (en_cnt == halt_at);
            if (!dbg_req) busy = 1'b0;
            if (dbg_req && !busy) begin
                busy     = 1'b1;
                req_addr = dbg_addr;
                req_mem  = dbg_is_mem;
                if (first_req < 0) first_req = cyc;
                check("req_addr", dbg_addr, tbl_addr[chk_idx]);
                check("req_is_mem", 32'(dbg_is_mem), 32'(tbl_is_mem[chk_idx]));
                if (delay_mode) begin
                    case ($urandom_range(0, 2))
                        0: dly = 0;
                        1: dly = 1;
                        default: dly = 5;
                    endcase
                end else dly = 0;
            end else if (dbg_req && busy) begin
                check("addr_stable", dbg_addr, req_addr);
            end
            if (busy) begin
                if (dly == 0) begin
                    dbg_ack   = 1'b1;
                    dbg_rdata = cpu_read(req_mem, req_addr);
                    busy      = 1'b0;
                    n_acks++;
                end else dly--;
            end else if (stray && !dbg_req) begin
                dbg_ack   = 1'b1;
                dbg_rdata = $urandom;
            end
        end
    end

    // One full run, with expectations derived from the table and CPU state
    task automatic run_prog(input int rl, input bit wh, input int h, input bit inj, input string nm);
        int exp_en, exp_fail, exp_first;
        bit halted, exp_to, injected;
        halted    = (h >= 1) && (h <= rl);
        exp_en    = halted ? h : rl;
        exp_to    = wh && !halted;
        exp_fail  = 0;
        exp_first = 0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            if (((cpu_read(tbl_is_mem[i], tbl_addr[i]) ^ tbl_exp[i]) & tbl_mask[i]) != '0) begin
                if (exp_fail == 0) exp_first = i;
                exp_fail++;
            end
        end
        @(negedge clk);
        run_len   = CNT_W'(rl);
        wait_halt = wh;
        halt_at   = h;
        en_cnt    = 0;
        rst_hi    = 0;
        n_acks    = 0;
        first_req = -1;
        start_cyc = cyc;
        active    = 1'b1;
        stray     = inj;
        injected  = 1'b0;
        start     = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (inj && !injected && cpu_en) begin
                start    = 1'b1;
                injected = 1'b1;
            end
            if (done) break;
        end
        start  = 1'b0;
        active = 1'b0;
        stray  = 1'b0;
        check({nm, ".done"},       32'(done), 32'd1);
        check({nm, ".pass"},       32'(pass), 32'((exp_fail == 0) && !exp_to));
        check({nm, ".timeout"},    32'(timeout), 32'(exp_to));
        check({nm, ".fail_count"}, 32'(fail_count), 32'(exp_fail));
        check({nm, ".first_fail"}, 32'(first_fail), 32'(exp_first));
        check({nm, ".en_cycles"},  32'(en_cnt), 32'(exp_en));
        check({nm, ".rst_cycles"}, 32'(rst_hi), 32'(RESET_CYCLES));
        check({nm, ".acks"},       32'(n_acks), 32'(NUM_CHECKS));
        check({nm, ".latency"},    32'(first_req - start_cyc), 32'(1 + RESET_CYCLES + exp_en));
        check({nm, ".frozen"},     {29'd0, cpu_en, cpu_rst, dbg_req}, 32'd0);
        halt_at = 0;
    endtask

    task automatic check_reset_vals(input string nm);
        check({nm, ".cpu_rst"},    32'(cpu_rst), 32'd1);
        check({nm, ".quiet"},      {28'd0, cpu_en, dbg_req, done, pass}, 32'd0);
        check({nm, ".timeout"},    32'(timeout), 32'd0);
        check({nm, ".fail_count"}, 32'(fail_count), 32'd0);
        check({nm, ".first_fail"}, 32'(first_fail), 32'd0);
        check({nm, ".chk_idx"},    32'(chk_idx), 32'd0);
    endtask

    initial begin
        load_program();
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("idle");

        run_prog(6, 1'b0, 0, 1'b0, "t1");

        set_entry(2, 1'b0, 32'd7, 32'd1, '1);
        run_prog(6, 1'b0, 0, 1'b0, "t2a");
        set_entry(4, 1'b0, 32'd3, 32'd99, '1);
        run_prog(6, 1'b0, 0, 1'b0, "t2b");

        load_program();
        run_prog(10, 1'b1, 0, 1'b0, "t3a");
        run_prog(10, 1'b1, 3, 1'b0, "t3b");
        run_prog(4, 1'b1, 4, 1'b0, "t3c");

        delay_mode = 1'b1;
        regs[11] = 32'h1234_565A;
        set_entry(5, 1'b0, 32'd11, 32'hAB00_005A, 32'h0000_00FF);
        run_prog(5, 1'b0, 0, 1'b0, "t4a");
        set_entry(6, 1'b0, 32'd11, 32'h1234_5650, 32'h0000_00FF);
        run_prog(5, 1'b0, 0, 1'b0, "t4b");

        // Reset asserted while entry 3 is being requested
        load_program();
        @(negedge clk);
        run_len = CNT_W'(6);
        wait_halt = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if ((chk_idx == IDX_W'(3)) && dbg_req) break;
            @(negedge clk);
        end
        check("abort.reached", 32'((chk_idx == IDX_W'(3)) && dbg_req), 32'd1);
        rst = 1'b0;
        #1;
        check_reset_vals("abort");
        @(negedge clk);
        rst = 1'b1;
        run_prog(6, 1'b0, 0, 1'b1, "t5a");
        run_prog(0, 1'b1, 0, 1'b0, "t5b");
        run_prog(0, 1'b0, 2, 1'b0, "t5c");

        // Randomized programs, tables and run parameters
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            for (int i = 0; i < 16; i++) mem[i] = $urandom;
            for (int i = 0; i < NUM_CHECKS; i++) begin
                logic              m;
                logic [DATA_W-1:0] a, v, e, k;
                m = 1'($urandom_range(0, 1));
                a = m ? DATA_W'($urandom_range(0, 15) * 4) : DATA_W'($urandom_range(0, 31));
                v = cpu_read(m, a);
                e = ($urandom_range(0, 1) == 0) ? v : (v ^ DATA_W'($urandom));
                k = ($urandom_range(0, 1) == 0) ? '1 : DATA_W'($urandom);
                set_entry(i, m, a, e, k);
            end
            run_prog($urandom_range(0, 12), 1'($urandom_range(0, 1)), $urandom_range(0, 14),
                     1'($urandom_range(0, 1)), $sformatf("rnd%0d", it));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
